// File: rtl/bram_pixel_writer.sv
// Port-A frame writer: streams MAX_ROW*MAX_COL pixels into BRAM from address 0.
// Define BRAM_WR_CHKSUM_EN to build the per-frame 16-bit byte-sum checksum.
module bram_pixel_writer #(
  parameter int MAX_ROW = 360,
  parameter int MAX_COL = 540
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_data_i,
  output logic        pix_ready_o,
  output logic        ena_o,
  output logic        wea_o,
  output logic [17:0] addra_o,
  output logic [7:0]  d2mema_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [7:0]  frame_cnt_o,
  output logic [15:0] chksum_o
);

  localparam int unsigned      FRAME_PIX = MAX_ROW * MAX_COL;
  localparam logic [17:0]      LAST_ADDR = 18'(FRAME_PIX - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic        ena_q, ena_d;
  logic        wea_q, wea_d;
  logic [17:0] addra_q, addra_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;

  // Handshake: a pixel is consumed on any cycle where pix_valid_i and
  // pix_ready_o are both high; ready depends only on state and abort_i.
  assign pix_ready_o = (state_q == WRITE) && !abort_i;
  assign accept      = pix_ready_o && pix_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    wea_d   = 1'b0;
    addra_d = addra_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          addr_d  = '0;
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (accept) begin
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = addr_q;
          data_d  = pix_data_i;
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            addr_d  = '0;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            addr_d = addr_q + 18'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ena_o        = ena_q;
  assign wea_o        = wea_q;
  assign addra_o      = addra_q;
  assign d2mema_o     = data_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == DONE);
  assign frame_cnt_o  = cnt_q;

`ifdef BRAM_WR_CHKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] chk_q, chk_d;

  always_comb begin
    acc_d = acc_q;
    chk_d = chk_q;
    if (state_q == IDLE && start_i) acc_d = '0;
    else if (accept)                acc_d = acc_q + {8'd0, pix_data_i};
    // The final pixel has landed in acc_q by the DONE cycle.
    if (state_q == DONE) chk_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      chk_q <= '0;
    end else begin
      acc_q <= acc_d;
      chk_q <= chk_d;
    end
  end

  assign chksum_o = chk_q;
`else
  assign chksum_o = 16'd0;
`endif

endmodule

// File: doc/bram_pixel_writer.md
Name: bram_pixel_writer

Overview:
- Port-A write controller for the frame-buffer BRAM.
- Accepts an 8-bit pixel stream over a valid/ready handshake and writes one frame of MAX_ROW*MAX_COL pixels to consecutive addresses starting at 0.
- Signals frame completion to the host side.
- Mirror of the port-B VGA read path, which scans the same BRAM.

Parameters:
MAX_ROW, 360, frame height in pixels
MAX_COL, 540, frame width in pixels; MAX_ROW*MAX_COL must be <= 2^18

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
start_i  input  1  arm a frame write; sampled only in IDLE
abort_i  input  1  cancel the current frame; honoured only in WRITE
pix_valid_i  input  1  pix_data_i valid
pix_data_i  input  8  pixel byte
pix_ready_o  output  1  block can accept a pixel this cycle
ena_o  output  1  BRAM port-A enable
wea_o  output  1  BRAM port-A write enable
addra_o  output  18  BRAM port-A address
d2mema_o  output  8  BRAM port-A write data
busy_o  output  1  high while not IDLE
frame_done_o  output  1  one-cycle pulse after the last pixel is written
frame_cnt_o  output  8  count of completed frames, wraps 255->0
chksum_o  output  16  frame checksum (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, internal pixel address 0.
- FSM states: IDLE, WRITE, DONE.
- IDLE -> WRITE on start_i=1. Address cleared to 0. Checksum cleared.
- WRITE:
  - pix_ready_o = 1 when abort_i=0. It is a combinational function of state and abort_i only, never of pix_valid_i.
  - Accept occurs when pix_valid_i & pix_ready_o.
  - On accept, next cycle: ena_o=1, wea_o=1, addra_o = address of the accepted pixel, d2mema_o = accepted byte. Latency is 1 cycle; all port-A outputs are registered.
  - Cycles without accept: ena_o=0, wea_o=0. addra_o and d2mema_o hold their last values.
  - Address increments by 1 per accept.
  - Accept at address MAX_ROW*MAX_COL-1 -> DONE. Address returns to 0.
  - abort_i=1 -> IDLE. Address cleared. No frame_done_o, frame_cnt_o unchanged. A pixel presented in the abort cycle is not accepted. Writes registered in earlier cycles still complete.
- DONE (one cycle):
  - frame_done_o=1, frame_cnt_o increments.
  - Coincides with the write of the last pixel on the port.
  - Unconditional -> IDLE.
- busy_o = (state != IDLE).
- Ignored inputs:
  - start_i in WRITE or DONE.
  - abort_i in IDLE or DONE.
  - pix_valid_i while pix_ready_o=0. The pixel is not consumed and the source must hold it.
- Back-to-back frames: start_i may be asserted in the cycle after DONE (first IDLE cycle). Minimum frame overhead is 2 idle cycles.
- Async reset mid-frame: immediate return to reset values; partially written frame contents in the BRAM are left as is.
- Read-only usage: the block never reads BRAM; no output path from port-A data.

Optional Feature:
- Macro: BRAM_WR_CHKSUM_EN.
- Defined:
  - 16-bit accumulator, cleared on IDLE->WRITE.
  - Adds zero-extended pix_data_i on every accept, modulo 2^16.
  - Copied to chksum_o in the DONE cycle; holds until the next DONE or reset.
- Undefined:
  - Accumulator not instantiated.
  - chksum_o tied to 16'd0.
  - Port list unchanged.

Test Plan:
(Benches use MAX_ROW=2, MAX_COL=3, i.e. a 6-pixel frame, unless noted.)
1. Reset, start_i pulse, stream bytes 0x10..0x15 with continuous valid -> six port-A writes at addr 0..5 with data 0x10..0x15, each 1 cycle after accept. frame_done_o single pulse aligned with the addr-5 write. frame_cnt_o=1. busy_o low afterwards.
2. Same stream with valid toggled every other cycle -> ena_o/wea_o high only in cycles after accepts. addr/data sequence identical to scenario 1, no duplicates or skips.
3. Stream 3 pixels, then abort_i=1 with pix_valid_i=1 -> pix_ready_o=0 in the abort cycle, no 4th write, state IDLE, frame_cnt_o unchanged. Next start_i restarts writes at addr 0.
4. pix_valid_i=1 in IDLE and start_i asserted during WRITE -> no accept and no write in IDLE; the mid-frame start has no effect on the address sequence.
5. Two back-to-back frames, start_i asserted in the first IDLE cycle after DONE -> second frame writes addr 0..5. frame_cnt_o=2. With BRAM_WR_CHKSUM_EN and data 0xFF x6, chksum_o=0x05FA after each frame.
6. Async reset asserted mid-frame at addr 2 -> all outputs 0 immediately. A later start_i writes from addr 0. Default-parameter run writes addr 0..194399 then wraps.
